// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: FSM state type, default operand
// width and the bit-counter width helper.
package calc_pkg;

   // Default operand/result width of the calculator datapath.
   localparam int unsigned CALC_WIDTH = 8;

   // Sequencer states of the bit-serial adder.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } calc_state_e;

   // Bits needed for a counter that can reach the value 'width'.
   function automatic int unsigned calc_cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   localparam int unsigned CALC_CNT_W = calc_cnt_width(CALC_WIDTH);

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// Single-bit combinational full adder cell used by the bit-serial adder.
module bit_serial_adder_full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: latches two operands on start, adds them LSB-first through one
// full-adder cell with a registered carry, then presents sum/carry with a done pulse.
// Optional subtract support is built when SERIAL_ADDER_SUB_EN is defined; otherwise
// i_sub is accepted but ignored.
module bit_serial_adder
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = CALC_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   input  logic             i_sub,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_busy,
   output logic             o_done
);

   localparam int unsigned      CNT_W    = calc_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   calc_state_e r_state;
   calc_state_e w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-2:0] r_res;    // sum bits produced so far, newest at the MSB
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_sum_carry;

   logic             w_sub;
   logic             w_sum_bit;
   logic             w_cout;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_sub = i_sub;
`else
   logic w_unused_sub;
   assign w_unused_sub = i_sub;
   assign w_sub        = 1'b0;
`endif

   bit_serial_adder_full_adder u_fa (
      .i_a   (r_a[0]),
      .i_b   (r_b[0]),
      .i_cin (r_carry),
      .o_sum (w_sum_bit),
      .o_cout(w_cout)
   );

   assign w_last     = (r_cnt == LAST_BIT);
   assign w_res_next = {w_sum_bit, r_res};

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: start only honoured in idle, done lasts one cycle.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (i_start) w_state_next = StRun;
         StRun:  if (w_last)  w_state_next = StDone;
         StDone: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Operand shifting, carry recirculation and result capture.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_sum_carry <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry.
                  r_a     <= i_A;
                  r_b     <= w_sub ? ~i_B : i_B;
                  r_carry <= w_sub;
                  r_cnt   <= '0;
               end
            end
            StRun: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_res   <= w_res_next[WIDTH-1:1];
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_sum       <= w_res_next;
                  r_sum_carry <= w_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_sum   = r_sum;
   assign o_carry = r_sum_carry;
   assign o_busy  = (r_state == StRun);
   assign o_done  = (r_state == StDone);

endmodule
